// File: rtl/av_char_sink.sv
// Avalon-MM character sink: byte writes to DATA_ADDR enter a FIFO drained on a valid/ready stream.
// Optional stall timeout (drop byte, flag overflow) is built when AV_CHAR_SINK_TIMEOUT_EN is defined.
module av_char_sink #(
    parameter int          FIFO_DEPTH     = 8,
    parameter logic [15:0] DATA_ADDR      = 16'h0100,
    parameter logic [15:0] STATUS_ADDR    = 16'h0101,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] av_address,
    input  logic        av_write,
    input  logic        av_read,
    input  logic [15:0] av_writedata,
    output logic [15:0] av_readdata,
    output logic        av_waitrequest,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_inc;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic [7:0]    head_reg;
    logic [7:0]    head_next;
    logic [6:0]    count_ext;
    logic          full;
    logic          empty;
    logic          data_wr;
    logic          stalled;
    logic          push;
    logic          pop;
    logic          timeout_hit;
    logic          overflow;
    logic          unused_sig;

    // Full comes from the registered count only, so a pop never releases a stalled push in the same cycle.
    assign full       = (count_reg == FULL_COUNT);
    assign empty      = (count_reg == '0);
    assign data_wr    = av_write && (av_address == DATA_ADDR);
    assign stalled    = data_wr && full;
    assign push       = data_wr && !full;
    assign pop        = !empty && tx_ready;
    assign rd_ptr_inc = rd_ptr_reg + 1'b1;
    assign count_ext  = 7'(count_reg);

    assign av_waitrequest = stalled && !timeout_hit;
    assign tx_valid       = !empty;
    assign tx_data        = head_reg;
    assign unused_sig     = ^{av_writedata[15:8], TIMEOUT_CYCLES[0]};

`ifdef AV_CHAR_SINK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] stall_cnt_reg;
    logic          overflow_reg;

    // On the terminal count the stalled write is acknowledged and its byte thrown away.
    assign timeout_hit = stalled && (stall_cnt_reg == TIMEOUT_LAST);
    assign overflow    = overflow_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_reg <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            if (stalled && !timeout_hit)
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            else
                stall_cnt_reg <= '0;

            if (timeout_hit)
                overflow_reg <= 1'b1;
            else if (av_write && (av_address == STATUS_ADDR) && av_writedata[15])
                overflow_reg <= 1'b0;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign overflow    = 1'b0;
`endif

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // head_reg tracks the byte that will sit at the FIFO head after this edge; it holds when empty.
    always_comb begin
        head_next = head_reg;
        if (pop) begin
            if (count_reg > CW'(1))
                head_next = mem[rd_ptr_inc];
            else if (push)
                head_next = av_writedata[7:0];
        end else if (empty && push) begin
            head_next = av_writedata[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= 8'h00;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_inc;
            count_reg <= count_next;
            head_reg  <= head_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= av_writedata[7:0];
    end

    // A read issued together with a write returns zero; reset forces zero regardless.
    always_comb begin
        av_readdata = 16'h0000;
        if (reset_n && av_read && !av_write) begin
            if (av_address == STATUS_ADDR)
                av_readdata = {overflow, full, empty, 6'b000000, count_ext};
            else if (av_address == DATA_ADDR)
                av_readdata = {8'h00, head_reg};
        end
    end

endmodule

// File: doc/av_char_sink.md
AV_CHAR_SINK -- requirements
Module: av_char_sink

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, meaning byte FIFO entries; it is a power of 2, range 2..64.
REQ-002 The block SHALL have parameter DATA_ADDR, default 16'h0100, meaning the character data register address.
REQ-003 The block SHALL have parameter STATUS_ADDR, default 16'h0101, meaning the status/control register address.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the stall limit before a byte is dropped; it is used only with the REQ-030 macro.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port av_address, input, 16 bits: Avalon-MM word address.
REQ-008 The block SHALL have port av_write, input, 1 bit: write strobe, held by the master until the transfer completes.
REQ-009 The block SHALL have port av_read, input, 1 bit: read strobe.
REQ-010 The block SHALL have port av_writedata, input, 16 bits: write data; bits 7:0 carry the character.
REQ-011 The block SHALL have port av_readdata, output, 16 bits: read data, valid in any cycle where av_read=1.
REQ-012 The block SHALL have port av_waitrequest, output, 1 bit: when high, the current transfer is stalled.
REQ-013 The block SHALL have port tx_data, output, 8 bits: head-of-FIFO byte.
REQ-014 The block SHALL have port tx_valid, output, 1 bit: tx_data is valid.
REQ-015 The block SHALL have port tx_ready, input, 1 bit: downstream accepts the byte when tx_valid and tx_ready are both high on a clock edge.

Function
REQ-016 The block SHALL act as an Avalon-MM responder with zero-wait reads and writes stalled only by a full FIFO.
REQ-017 A write to DATA_ADDR while the registered count is below FIFO_DEPTH SHALL complete in the same cycle, with av_waitrequest=0 and av_writedata[7:0] pushed at the clock edge.
REQ-018 A write to DATA_ADDR while the FIFO is full SHALL hold av_waitrequest=1, combinationally from av_write, the address match and the full flag, until space exists; the push occurs in the first cycle av_waitrequest=0.
REQ-019 Full SHALL be evaluated from the registered count only; on a simultaneous pop and stalled push while full, the push remains stalled that cycle and completes the next cycle, giving exactly one extra wait cycle.
REQ-020 Latency SHALL be as follows: a byte pushed at edge N drives tx_valid=1 with tx_data equal to that byte after edge N.
REQ-021 Pop SHALL occur on an edge with tx_valid and tx_ready both high; an empty FIFO drives tx_valid=0, and tx_data holds its last value.
REQ-022 Push and pop in the same cycle while the FIFO is not full and not empty SHALL leave the count unchanged; the pointers wrap modulo FIFO_DEPTH, and the count is log2(FIFO_DEPTH)+1 bits wide.
REQ-023 A read of STATUS_ADDR SHALL return av_readdata with bit15=overflow (sticky), bit14=full, bit13=empty, bits 6:0=count, and other bits 0.
REQ-024 A write to STATUS_ADDR with av_writedata[15]=1 SHALL clear overflow; all other bits of that write are ignored and no wait state is inserted.
REQ-025 A read of DATA_ADDR SHALL return {8'h00, head byte} without popping; reads of any other address return 16'h0000.
REQ-026 Writes to any other address SHALL complete with av_waitrequest=0 and no effect.
REQ-027 Simultaneous av_read and av_write SHALL be treated as a write only, with av_readdata=0.

Reset
REQ-028 Assertion of reset_n=0 SHALL immediately clear pointers, count, overflow and the stall counter, and drive tx_valid=0, tx_data=8'h00, av_waitrequest=0 and av_readdata=0; FIFO contents need not be cleared.
REQ-029 Reset asserted mid-stall SHALL drop the pending write with no push; reset released mid-stream SHALL restart from an empty FIFO.

Configuration
REQ-030 The block SHALL support macro AV_CHAR_SINK_TIMEOUT_EN: when defined, a counter increments each cycle a DATA_ADDR write is stalled; when it reaches TIMEOUT_CYCLES-1, av_waitrequest is forced to 0 for one cycle, the byte is discarded, overflow is set, and the counter clears; the counter also clears on any completed or absent write.
REQ-031 When AV_CHAR_SINK_TIMEOUT_EN is undefined, the block SHALL stall indefinitely, keep overflow permanently 0, and contain no counter logic.

Verification
REQ-032 The bench SHALL cover: tx_ready=1, write 16'h0031 to 0x0100 -> av_waitrequest=0, tx_valid=1 with tx_data=8'h31 the next cycle, popped one cycle later.
REQ-033 The bench SHALL cover: tx_ready=0, 8 writes of bytes 0x41..0x48 -> STATUS reads 16'h4008; 9th write stalls; one tx_ready pulse then completes the 9th write after exactly 2 cycles of waitrequest=1.
REQ-034 The bench SHALL cover: drain the FIFO after 12 pushes/pops with FIFO_DEPTH=8 -> bytes emerge in order across pointer wrap, and STATUS reads 16'h2000.
REQ-035 The bench SHALL cover: with AV_CHAR_SINK_TIMEOUT_EN defined and TIMEOUT_CYCLES=16, hold a write to a full FIFO -> waitrequest drops after 16 cycles, count stays 8, STATUS bit15=1, and a write of 16'h8000 to 0x0101 clears it.
REQ-036 The bench SHALL cover: assert reset_n during a stalled write with 5 bytes queued -> outputs reach reset values asynchronously, and a post-reset STATUS read returns 16'h2000.
